// File: rtl/pim_job_arbiter_pkg.sv
// Shared types for the PIM job arbiter: address width, default requester count
// and the arbiter FSM encoding.
package pim_job_arbiter_pkg;

  localparam int LEN         = 32;
  localparam int PIM_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/pim_job_arbiter_rr_select.sv
// Round-robin selector: first valid requester searched upward from (last_i + 1)
// modulo NUM_REQ. Purely combinational.
module rr_select
  import pim_job_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = PIM_NUM_REQ,
  localparam int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDXW-1:0]    last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDXW-1:0]    idx_o,
  output logic               any_o
);

  int            cand;
  logic [IDXW-1:0] cand_idx;

  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_i) + k) % NUM_REQ;
      cand_idx = IDXW'(cand);
      if (!any_o && valid_i[cand_idx]) begin
        any_o             = 1'b1;
        idx_o             = cand_idx;
        grant_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pim_job_arbiter.sv
// Round-robin job arbiter in front of a shared matrix engine.
// Optional WAIT watchdog enabled by defining PIM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | grant one requester, latch its addresses and index
// ISSUE | one-cycle eng_start to the engine
// WAIT  | engine running; only here is eng_done honoured
// RESP  | one-cycle req_done (and req_err on watchdog expiry) to the owner
module pim_job_arbiter
  import pim_job_arbiter_pkg::*;
#(
  parameter  int NUM_REQ        = PIM_NUM_REQ,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IDXW           = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][LEN-1:0]   req_src1_addr,
  input  logic [NUM_REQ-1:0][LEN-1:0]   req_src2_addr,
  input  logic [NUM_REQ-1:0][LEN-1:0]   req_dst_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_err,
  output logic                          eng_start,
  output logic [LEN-1:0]                eng_src1_addr,
  output logic [LEN-1:0]                eng_src2_addr,
  output logic [LEN-1:0]                eng_dst_addr,
  input  logic                          eng_done,
  output logic                          busy,
  output logic [IDXW-1:0]               owner
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("pim_job_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  arb_state_t      state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [LEN-1:0]  src1_q, src1_d;
  logic [LEN-1:0]  src2_q, src2_d;
  logic [LEN-1:0]  dst_q, dst_d;

  logic [NUM_REQ-1:0] rr_grant;
  logic [IDXW-1:0]    rr_idx;
  logic               rr_any;
  logic [NUM_REQ-1:0] owner_oh;
  logic               tmo_hit;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .valid_i (req_valid),
    .last_i  (last_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .any_o   (rr_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDXW'(NUM_REQ - 1);
      src1_q  <= '0;
      src2_q  <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dst_q   <= dst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    dst_d   = dst_q;
    case (state_q)
      IDLE: begin
        if (rr_any) begin
          state_d = ISSUE;
          owner_d = rr_idx;
          src1_d  = req_src1_addr[rr_idx];
          src2_d  = req_src2_addr[rr_idx];
          dst_d   = req_dst_addr[rr_idx];
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (eng_done || tmo_hit) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign owner_oh      = NUM_REQ'(1) << owner_q;
  assign req_ready     = (state_q == IDLE) ? rr_grant : '0;
  assign req_done      = (state_q == RESP) ? owner_oh : '0;
  assign eng_start     = (state_q == ISSUE);
  assign busy          = (state_q != IDLE);
  assign owner         = owner_q;
  assign eng_src1_addr = src1_q;
  assign eng_src2_addr = src2_q;
  assign eng_dst_addr  = dst_q;

`ifdef PIM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // Loaded in ISSUE so the terminal count lands on the TIMEOUT_CYCLES-th WAIT cycle.
  assign tmo_hit = (state_q == WAIT) && (tmo_q == '0);

  always_comb begin
    tmo_d = '0;
    if (state_q == ISSUE) begin
      tmo_d = CW'(TIMEOUT_CYCLES - 1);
    end else if (state_q == WAIT && tmo_q != '0) begin
      tmo_d = tmo_q - CW'(1);
    end
  end

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE) begin
      err_d = 1'b0;
    end else if (state_q == WAIT && !eng_done && tmo_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign req_err = (state_q == RESP && err_q) ? owner_oh : '0;
`else
  assign tmo_hit = 1'b0;
  assign req_err = '0;
`endif

endmodule

// File: tb/tb_pim_job_arbiter.sv
// Self-checking bench for pim_job_arbiter with a behavioural round-robin model.
module tb_pim_job_arbiter;
  import pim_job_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req_valid;
  logic [N-1:0][LEN-1:0] a1, a2, a3;
  logic [N-1:0]          req_ready, req_done, req_err;
  logic                  eng_start;
  logic [LEN-1:0]        e_src1, e_src2, e_dst;
  logic                  eng_done;
  logic                  busy;
  logic [1:0]            owner;

  pim_job_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_src1_addr (a1),
    .req_src2_addr (a2),
    .req_dst_addr  (a3),
    .req_ready     (req_ready),
    .req_done      (req_done),
    .req_err       (req_err),
    .eng_start     (eng_start),
    .eng_src1_addr (e_src1),
    .eng_src2_addr (e_src2),
    .eng_dst_addr  (e_dst),
    .eng_done      (eng_done),
    .busy          (busy),
    .owner         (owner)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_last;
  int   starts_seen = 0;
  int   starts_exp = 0;
  int   double_start = 0;
  logic prev_start = 1'b0;

  always @(posedge clk) begin
    if (eng_start === 1'b1) starts_seen++;
    if (eng_start === 1'b1 && prev_start) double_start++;
    prev_start = (eng_start === 1'b1);
  end

  // Reference: requesters ranked in rotation order starting after the last owner.
  function automatic int model_pick(input logic [N-1:0] v, input int last);
    int order[$];
    for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic rand_addrs();
    for (int i = 0; i < N; i++) begin
      a1[i] = $urandom;
      a2[i] = $urandom;
      a3[i] = $urandom;
    end
  endtask

  task automatic do_job(input logic [N-1:0] v, input int d, input bit scramble,
                        input bit spurious, input string tag);
    int w;
    logic [N-1:0] oh;
    logic [LEN-1:0] x1, x2, x3;
    req_valid = v;
    eng_done  = spurious;
    #1;
    w  = model_pick(v, exp_last);
    oh = N'(1) << w;
    n_cmp++; if (req_ready !== oh) begin n_err++; $display("FAIL %s grant: got %b want %b", tag, req_ready, oh); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s idle_busy: got %b want 0", tag, busy); end
    x1 = a1[w]; x2 = a2[w]; x3 = a3[w];
    @(negedge clk);
    rand_addrs();
    if (scramble) req_valid = N'($urandom);
    eng_done = spurious;
    #1;
    starts_exp++;
    n_cmp++; if (eng_start !== 1'b1) begin n_err++; $display("FAIL %s start: got %b want 1", tag, eng_start); end
    n_cmp++; if (owner !== 2'(w)) begin n_err++; $display("FAIL %s owner: got %0d want %0d", tag, owner, w); end
    n_cmp++; if ({e_src1, e_src2, e_dst} !== {x1, x2, x3}) begin n_err++;
      $display("FAIL %s addr: got %h/%h/%h want %h/%h/%h", tag, e_src1, e_src2, e_dst, x1, x2, x3); end
    n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL %s issue_ready: got %b want 0", tag, req_ready); end
    for (int c = 2; c <= d; c++) begin
      @(negedge clk);
      eng_done = 1'b0;
      if (scramble) req_valid = N'($urandom);
      #1;
      n_cmp++; if ({eng_start, req_done, req_ready, busy} !== {1'b0, N'(0), N'(0), 1'b1}) begin n_err++;
        $display("FAIL %s wait: got start=%b done=%b ready=%b busy=%b want 0/0/0/1", tag, eng_start, req_done, req_ready, busy); end
    end
    @(negedge clk);
    eng_done = 1'b1;
    #1;
    n_cmp++; if (req_done !== '0) begin n_err++; $display("FAIL %s early_done: got %b want 0", tag, req_done); end
    @(negedge clk);
    eng_done = 1'b0;
    if (scramble) req_valid = '0;
    #1;
    n_cmp++; if (req_done !== oh) begin n_err++; $display("FAIL %s done: got %b want %b", tag, req_done, oh); end
    n_cmp++; if (req_err !== '0) begin n_err++; $display("FAIL %s err: got %b want 0", tag, req_err); end
    n_cmp++; if ({e_src1, e_src2, e_dst} !== {x1, x2, x3}) begin n_err++;
      $display("FAIL %s resp_addr: got %h/%h/%h want %h/%h/%h", tag, e_src1, e_src2, e_dst, x1, x2, x3); end
    @(negedge clk);
    exp_last = w;
    #1;
    n_cmp++; if ({req_done, busy} !== {N'(0), 1'b0}) begin n_err++;
      $display("FAIL %s back_idle: got done=%b busy=%b want 0/0", tag, req_done, busy); end
    if (scramble) begin
      n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL %s dropped_req: got %b want 0", tag, req_ready); end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    eng_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_last = N - 1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '0; eng_done = 1'b0;
    a1 = '0; a2 = '0; a3 = '0;
    #12;
    n_cmp++; if ({busy, eng_start, req_done, req_err, req_ready, owner} !== '0) begin n_err++;
      $display("FAIL reset_ctl: got busy=%b start=%b done=%b err=%b ready=%b owner=%0d want all 0",
               busy, eng_start, req_done, req_err, req_ready, owner); end
    n_cmp++; if ({e_src1, e_src2, e_dst} !== '0) begin n_err++;
      $display("FAIL reset_addr: got %h/%h/%h want 0", e_src1, e_src2, e_dst); end
    @(negedge clk);
    rst = 1'b1;
    exp_last = N - 1;
  endtask

  task automatic test_rr_all();
    apply_reset();
    for (int j = 0; j < 5; j++) begin
      rand_addrs();
      do_job(4'b1111, 2, 1'b0, 1'b0, "rr_all");
    end
  endtask

  task automatic test_alt();
    rand_addrs();
    do_job(4'b0001, 1, 1'b0, 1'b0, "alt_own0");
    do_job(4'b0101, 3, 1'b0, 1'b0, "alt_a");
    do_job(4'b0101, 1, 1'b0, 1'b0, "alt_b");
  endtask

  task automatic test_single();
    rand_addrs();
    a1[2] = 32'h10; a2[2] = 32'h20; a3[2] = 32'h30;
    do_job(4'b0100, 5, 1'b0, 1'b0, "single2");
  endtask

  task automatic test_spurious();
    req_valid = '0;
    eng_done  = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    #1;
    n_cmp++; if ({busy, req_done} !== {1'b0, N'(0)}) begin n_err++;
      $display("FAIL spur_idle: got busy=%b done=%b want 0/0", busy, req_done); end
    rand_addrs();
    do_job(4'b0010, 3, 1'b0, 1'b1, "spurious");
  endtask

  task automatic test_reset_mid();
    rand_addrs();
    req_valid = 4'b1000;
    @(negedge clk);
    starts_exp++;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if ({busy, owner, req_done, e_src1} !== '0) begin n_err++;
      $display("FAIL midrst: got busy=%b owner=%0d done=%b src1=%h want 0", busy, owner, req_done, e_src1); end
    @(negedge clk);
    rst = 1'b1;
    exp_last = N - 1;
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if ({busy, req_done} !== {1'b0, N'(0)}) begin n_err++;
        $display("FAIL midrst_ghost: got busy=%b done=%b want 0/0", busy, req_done); end
      @(negedge clk);
    end
    rand_addrs();
    do_job(4'b1111, 2, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    for (int j = 0; j < 14; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        #1;
        n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL rnd_idle: got %b want 0", req_ready); end
        @(negedge clk);
      end
      v = N'($urandom_range(1, 15));
      rand_addrs();
      do_job(v, $urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'b0, "random");
    end
`ifndef PIM_ARB_TIMEOUT_EN
    rand_addrs();
    do_job(4'b0110, 40, 1'b1, 1'b0, "long_wait");
`endif
  endtask

`ifdef PIM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int w;
    logic [N-1:0] oh;
    rand_addrs();
    req_valid = 4'b1001;
    w  = model_pick(4'b1001, exp_last);
    oh = N'(1) << w;
    @(negedge clk);
    req_valid = '0;
    starts_exp++;
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (req_done !== '0) begin n_err++; $display("FAIL tmo_early: cycle %0d got %b want 0", c, req_done); end
    end
    @(negedge clk);
    #1;
    n_cmp++; if ({req_done, req_err} !== {oh, oh}) begin n_err++;
      $display("FAIL tmo_fire: got done=%b err=%b want %b/%b", req_done, req_err, oh, oh); end
    @(negedge clk);
    exp_last = w;
    rand_addrs();
    do_job(4'b0100, TMO, 1'b0, 1'b0, "tmo_edge");
  endtask
`endif

  initial begin
    test_reset();
    test_rr_all();
    test_alt();
    test_single();
    test_spurious();
    test_reset_mid();
    test_random();
`ifdef PIM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    @(negedge clk);
    n_cmp++; if (starts_seen !== starts_exp) begin n_err++;
      $display("FAIL start_count: got %0d want %0d", starts_seen, starts_exp); end
    n_cmp++; if (double_start !== 0) begin n_err++;
      $display("FAIL start_width: got %0d back-to-back starts want 0", double_start); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pim_job_arbiter.md
PIM_JOB_ARBITER -- requirements
Module: pim_job_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the matrix engine (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit in WAIT (used only with PIM_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester job request.
REQ-006 SHALL have ports req_src1_addr, req_src2_addr, req_dst_addr  input  [NUM_REQ][LEN]  per-requester matrix A, matrix B and result base addresses.
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot accept; a job transfers when req_valid[i] and req_ready[i] are both high.
REQ-008 SHALL have port req_done  output  NUM_REQ  one-cycle completion pulse to the job owner.
REQ-009 SHALL have port req_err  output  NUM_REQ  one-cycle error flag, coincident with req_done.
REQ-010 SHALL have port eng_start  output  1  one-cycle start pulse to the matrix engine.
REQ-011 SHALL have ports eng_src1_addr, eng_src2_addr, eng_dst_addr  output  LEN  latched job addresses, stable from ISSUE through RESP.
REQ-012 SHALL have port eng_done  input  1  engine completion pulse.
REQ-013 SHALL have ports busy  output  1  (state != IDLE) and owner  output  $clog2(NUM_REQ)  index of the current job's requester.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: if any req_valid, SHALL assert req_ready for exactly one winner in the same cycle (combinational), latch its three addresses and its index into owner, and go to ISSUE; otherwise remain in IDLE.
REQ-016 Winner SHALL be selected round-robin: first valid index searched upward from (last_owner+1) mod NUM_REQ.
REQ-017 ISSUE: SHALL drive eng_start=1 for exactly one cycle, then go to WAIT.
REQ-018 WAIT: eng_done=1 SHALL move to RESP; eng_done in any other state SHALL be ignored.
REQ-019 RESP: SHALL drive req_done[owner]=1 for one cycle, set last_owner to owner, and return to IDLE.
REQ-020 Accept-to-start latency SHALL be 1 cycle; eng_done-to-req_done latency SHALL be 1 cycle; minimum job turnaround is 4 cycles plus engine time.
REQ-021 req_ready SHALL be all-zero outside IDLE; a requester dropping req_valid before acceptance SHALL be neither granted nor recorded.
REQ-022 A requester that holds req_valid high after its own req_done SHALL compete again under round-robin order; it SHALL NOT win ahead of other valid requesters.
REQ-023 req_done, req_err and eng_start SHALL never be high in more than one bit or more than one consecutive cycle per job.

Reset
REQ-024 On rst low, SHALL asynchronously force state=IDLE, last_owner=NUM_REQ-1, owner=0, all addresses 0, eng_start=0, req_done=0, req_err=0, busy=0, timeout counter=0.
REQ-025 Reset mid-job SHALL abandon the job without any req_done; a subsequent eng_done SHALL be ignored.

Configuration
REQ-026 With PIM_ARB_TIMEOUT_EN defined: SHALL count cycles in WAIT; on reaching TIMEOUT_CYCLES without eng_done, SHALL go to RESP with req_err[owner]=1 and req_done[owner]=1; eng_done in the same cycle as the limit SHALL take priority (req_err=0).
REQ-027 Without PIM_ARB_TIMEOUT_EN: SHALL contain no counter, SHALL wait indefinitely in WAIT, and req_err SHALL be constant 0.

Structure
REQ-028 LEN SHALL come from the shared types package; the arbiter state enum and a PIM_NUM_REQ default constant SHALL be added there.
REQ-029 The round-robin selector SHALL be one sub-module, rr_select (inputs: valid vector, last index; outputs: one-hot grant, index, any).

Verification
REQ-030 Single req_valid[2] with addresses 0x10/0x20/0x30: req_ready[2] same cycle, eng_start the next cycle with those addresses, eng_done after 5 cycles -> req_done[2] one cycle later, req_err=0.
REQ-031 req_valid=4'b1111 held continuously from reset: grant order 0,1,2,3,0, with exactly one eng_start per job.
REQ-032 req_valid=4'b0101 after a job owned by requester 0: the next grant goes to 2, then 0.
REQ-033 eng_done pulsed while in IDLE and ISSUE: no state change; the job completes only on eng_done in WAIT.
REQ-034 rst low during WAIT, then eng_done: no req_done; busy=0; the next grant goes to requester 0.
REQ-035 PIM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no eng_done: req_done and req_err on owner 17 cycles after eng_start; a separate run with eng_done on the limit cycle gives req_err=0.
